common_fifo_wrarb_rr: RTL

COMMON_FIFO_WRARB_RR -- requirements
Module: common_fifo_wrarb_rr

---
 rtl/common_fifo_wrarb_rr.sv | 123 ++++++++++++
 1 files changed

// File: rtl/common_fifo_wrarb_rr.sv
// Round-robin write arbiter for a single FIFO write port.
// Owners hold the port for bounded bursts; handover happens without a dead cycle.
module common_fifo_wrarb_rr #(
    parameter int ARB_PORTS_LOG2 = 2,
    parameter int ARB_WIDTH      = 1,
    parameter int ARB_BURST_MAX  = 4
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [(1<<ARB_PORTS_LOG2)-1:0]               req,
    input  logic [(1<<ARB_PORTS_LOG2)*ARB_WIDTH-1:0]     req_data,
    output logic [(1<<ARB_PORTS_LOG2)-1:0]               gnt,
    output logic [ARB_WIDTH-1:0]                         fifo_din,
    output logic                                         fifo_wen,
    input  logic                                         fifo_full,
    output logic [ARB_PORTS_LOG2-1:0]                    owner,
    output logic                                         locked
);

    localparam int N = 1 << ARB_PORTS_LOG2;
    localparam logic [ARB_PORTS_LOG2-1:0] IDX_ONE = 1;
    localparam logic [7:0] BURST_LIM = 8'(ARB_BURST_MAX);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t                    state;
    state_t                    state_n;
    logic [ARB_PORTS_LOG2-1:0] rr_ptr;
    logic [ARB_PORTS_LOG2-1:0] rr_ptr_n;
    logic [ARB_PORTS_LOG2-1:0] owner_n;
    logic [7:0]                count;
    logic [7:0]                count_n;

    logic                      hold_owner;
    logic                      found;
    logic                      grant;
    logic [ARB_PORTS_LOG2-1:0] start;
    logic [ARB_PORTS_LOG2-1:0] cand;
    logic [ARB_PORTS_LOG2-1:0] pick;
    logic [ARB_PORTS_LOG2-1:0] sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            count  <= '0;
        end else begin
            state  <= state_n;
            rr_ptr <= rr_ptr_n;
            owner  <= owner_n;
            count  <= count_n;
        end
    end

    // A locked owner that dropped its request hands over starting after itself.
    always_comb begin
        hold_owner = (state == LOCKED) && req[owner];
        start      = (state == LOCKED) ? owner + IDX_ONE : rr_ptr;
        found      = 1'b0;
        pick       = '0;
        cand       = '0;
        for (int k = 0; k < N; k++) begin
            cand = start + ARB_PORTS_LOG2'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        grant = !reset && !fifo_full && (hold_owner || found);
        sel   = hold_owner ? owner : pick;
    end

    always_comb begin
        state_n  = state;
        rr_ptr_n = rr_ptr;
        owner_n  = owner;
        count_n  = count;
        if (grant) begin
            if (hold_owner) begin
                count_n = count + 8'd1;
                if (count_n == BURST_LIM) begin
                    state_n  = IDLE;
                    rr_ptr_n = owner + IDX_ONE;
                    count_n  = '0;
                end
            end else if (ARB_BURST_MAX == 1) begin
                state_n  = IDLE;
                rr_ptr_n = pick + IDX_ONE;
                owner_n  = pick;
                count_n  = '0;
            end else begin
                state_n = LOCKED;
                owner_n = pick;
                count_n = 8'd1;
            end
        end else if (!fifo_full && state == LOCKED) begin
            state_n  = IDLE;
            rr_ptr_n = owner + IDX_ONE;
            count_n  = '0;
        end
    end

    always_comb begin
        gnt      = '0;
        fifo_din = '0;
        if (grant) begin
            gnt[sel] = 1'b1;
            for (int k = 0; k < N; k++) begin
                if (ARB_PORTS_LOG2'(k) == sel) begin
                    fifo_din = req_data[k*ARB_WIDTH +: ARB_WIDTH];
                end
            end
        end
    end

    assign fifo_wen = grant;
    assign locked   = (state == LOCKED);

endmodule
